// File: rtl/scaler_frame_ctrl.sv
// Frame-level gate in front of the bilinear scaler: qualifies the DVP input stream, opens the
// gate only on frame boundaries, checks line/frame geometry and waits for the scaler to drain.
module scaler_frame_ctrl #(
    parameter int unsigned C_HREF_LEN       = 1920,
    parameter int unsigned C_SRC_IMG_HEIGHT = 480,
    parameter int unsigned C_DRAIN_MIN      = 4,
    parameter int unsigned C_DRAIN_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic        per_img_vsync,
    input  logic        per_img_href,
    input  logic [7:0]  per_img_gray,
    input  logic        scaler_busy,
    output logic        gate_img_vsync,
    output logic        gate_img_href,
    output logic [7:0]  gate_img_gray,
    output logic        busy,
    output logic        frame_done,
    output logic        geom_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic [11:0] last_line_len,
    output logic [9:0]  last_line_cnt
);

    localparam logic [11:0] HrefLen   = 12'(C_HREF_LEN);
    localparam logic [9:0]  ImgHeight = 10'(C_SRC_IMG_HEIGHT);
    localparam logic [15:0] DrainMin  = 16'(C_DRAIN_MIN);
    localparam logic [15:0] DrainLast = 16'(C_DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDrain} state_e;

    state_e      state_q, state_d;
    logic        in_vsync_q, in_vsync_d;
    logic        in_href_q, in_href_d;
    logic [7:0]  in_gray_q, in_gray_d;
    logic        dly_vsync_q, dly_vsync_d;
    logic        dly_href_q, dly_href_d;
    logic        busy_meta_q, busy_meta_d;
    logic        busy_sync_q, busy_sync_d;
    logic        stop_pend_q, stop_pend_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        geom_err_q, geom_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [11:0] last_line_len_q, last_line_len_d;
    logic [9:0]  last_line_cnt_q, last_line_cnt_d;

    logic        vsync_rise, href_fall, href_rise, gate_open;
    logic [9:0]  line_inc;

    assign vsync_rise = in_vsync_q & ~dly_vsync_q;
    assign href_fall  = ~in_href_q & dly_href_q;
    assign href_rise  = in_href_q & ~dly_href_q;
    assign line_inc   = line_cnt_q + 10'd1;

    always_comb begin
        in_vsync_d  = per_img_vsync;
        in_href_d   = per_img_href;
        in_gray_d   = per_img_gray;
        dly_vsync_d = in_vsync_q;
        dly_href_d  = in_href_q;
        busy_meta_d = scaler_busy;
        busy_sync_d = busy_meta_q;
    end

    always_comb begin
        state_d         = state_q;
        stop_pend_d     = stop_pend_q;
        pix_cnt_d       = pix_cnt_q;
        line_cnt_d      = line_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        frame_done_d    = 1'b0;
        geom_err_d      = 1'b0;
        timeout_err_d   = 1'b0;
        frame_cnt_d     = frame_cnt_q;
        last_line_len_d = last_line_len_q;
        last_line_cnt_d = last_line_cnt_q;
        gate_open       = 1'b0;

        unique case (state_q)
            StIdle: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (stop || stop_pend_q) begin
                    state_d = StIdle;
                end else if (vsync_rise) begin
                    // Open on the vsync-rise cycle itself so the scaler sees the frame start.
                    state_d    = StRun;
                    pix_cnt_d  = 12'd0;
                    line_cnt_d = 10'd0;
                    gate_open  = 1'b1;
                end
            end
            StRun: begin
                gate_open = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (in_href_q && pix_cnt_q != 12'hfff) begin
                    pix_cnt_d = pix_cnt_q + 12'd1;
                end
                if (vsync_rise) begin
                    // Short frame: resync onto the new frame without leaving RUN.
                    geom_err_d      = 1'b1;
                    last_line_cnt_d = line_cnt_q;
                    pix_cnt_d       = 12'd0;
                    line_cnt_d      = 10'd0;
                end else if (href_fall) begin
                    last_line_len_d = pix_cnt_q;
                    pix_cnt_d       = 12'd0;
                    if (pix_cnt_q != HrefLen) begin
                        geom_err_d = 1'b1;
                        state_d    = StArm;
                        gate_open  = 1'b0;
                    end else begin
                        line_cnt_d = line_inc;
                        if (line_inc == ImgHeight) begin
                            state_d         = StDrain;
                            drain_cnt_d     = 16'd0;
                            last_line_cnt_d = line_inc;
                            gate_open       = 1'b0;
                        end
                    end
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 16'd1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (href_rise) begin
                    geom_err_d = 1'b1;
                end
                if (drain_cnt_q >= DrainMin && !busy_sync_q) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    state_d      = (continuous && !stop_pend_q && !stop) ? StArm : StIdle;
                end else if (drain_cnt_q == DrainLast) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = (state_d != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            in_vsync_q      <= 1'b0;
            in_href_q       <= 1'b0;
            in_gray_q       <= 8'd0;
            dly_vsync_q     <= 1'b0;
            dly_href_q      <= 1'b0;
            busy_meta_q     <= 1'b0;
            busy_sync_q     <= 1'b0;
            stop_pend_q     <= 1'b0;
            pix_cnt_q       <= 12'd0;
            line_cnt_q      <= 10'd0;
            drain_cnt_q     <= 16'd0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            geom_err_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
            frame_cnt_q     <= 16'd0;
            last_line_len_q <= 12'd0;
            last_line_cnt_q <= 10'd0;
        end else begin
            state_q         <= state_d;
            in_vsync_q      <= in_vsync_d;
            in_href_q       <= in_href_d;
            in_gray_q       <= in_gray_d;
            dly_vsync_q     <= dly_vsync_d;
            dly_href_q      <= dly_href_d;
            busy_meta_q     <= busy_meta_d;
            busy_sync_q     <= busy_sync_d;
            stop_pend_q     <= stop_pend_d;
            pix_cnt_q       <= pix_cnt_d;
            line_cnt_q      <= line_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            geom_err_q      <= geom_err_d;
            timeout_err_q   <= timeout_err_d;
            frame_cnt_q     <= frame_cnt_d;
            last_line_len_q <= last_line_len_d;
            last_line_cnt_q <= last_line_cnt_d;
        end
    end

    // Gated stream comes straight off the input registers, so reset zeroes it asynchronously.
    assign gate_img_vsync = gate_open & in_vsync_q;
    assign gate_img_href  = gate_open & in_href_q;
    assign gate_img_gray  = gate_open ? in_gray_q : 8'd0;

    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign geom_err      = geom_err_q;
    assign timeout_err   = timeout_err_q;
    assign frame_cnt     = frame_cnt_q;
    assign last_line_len = last_line_len_q;
    assign last_line_cnt = last_line_cnt_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Scoreboard bench for scaler_frame_ctrl: the driver queues expected gated pixels and status
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_scaler_frame_ctrl;

    localparam int HREF_LEN = 16;
    localparam int HEIGHT   = 8;
    localparam int DRAIN_TO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic        per_img_vsync = 1'b0, per_img_href = 1'b0;
    logic [7:0]  per_img_gray = 8'd0;
    logic        scaler_busy = 1'b0;
    logic        gate_img_vsync, gate_img_href;
    logic [7:0]  gate_img_gray;
    logic        busy, frame_done, geom_err, timeout_err;
    logic [15:0] frame_cnt;
    logic [11:0] last_line_len;
    logic [9:0]  last_line_cnt;

    scaler_frame_ctrl #(
        .C_HREF_LEN      (HREF_LEN),
        .C_SRC_IMG_HEIGHT(HEIGHT),
        .C_DRAIN_MIN     (4),
        .C_DRAIN_TIMEOUT (DRAIN_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .per_img_vsync (per_img_vsync),
        .per_img_href  (per_img_href),
        .per_img_gray  (per_img_gray),
        .scaler_busy   (scaler_busy),
        .gate_img_vsync(gate_img_vsync),
        .gate_img_href (gate_img_href),
        .gate_img_gray (gate_img_gray),
        .busy          (busy),
        .frame_done    (frame_done),
        .geom_err      (geom_err),
        .timeout_err   (timeout_err),
        .frame_cnt     (frame_cnt),
        .last_line_len (last_line_len),
        .last_line_cnt (last_line_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 frame_done, 1 geom_err (bad line length), 2 geom_err (short frame), 3 timeout_err
    typedef struct {
        int     kind;
        int     fcnt;
        int     lcnt;
        int     llen;
        longint at;
        bit     exp_busy;
    } evt_t;

    logic [7:0] pix_q[$];
    evt_t       evt_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_frames = 0;
    longint     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every gated href beat must match a queued pixel; every status pulse a queued event.
    always @(negedge clk) begin
        if (!rst) begin
            if (gate_img_href) begin
                check_eq("gated_href_expected", pix_q.size() != 0, 1);
                if (pix_q.size() != 0) check_eq("gated_gray", gate_img_gray, pix_q.pop_front());
            end
            if (frame_done || geom_err || timeout_err) begin
                check_eq("event_expected", evt_q.size() != 0, 1);
                if (evt_q.size() != 0) begin
                    evt_t e;
                    int   obs_kind;
                    e = evt_q.pop_front();
                    obs_kind = frame_done ? 0 : (geom_err ? 1 : 3);
                    check_eq("event_kind", obs_kind, (e.kind == 2) ? 1 : e.kind);
                    case (e.kind)
                        0: begin
                            check_eq("done_frame_cnt", frame_cnt, e.fcnt);
                            check_eq("done_line_cnt", last_line_cnt, e.lcnt);
                            check_eq("done_line_len", last_line_len, e.llen);
                            check_eq("done_cycle", cyc, e.at);
                            check_eq("done_busy", busy, e.exp_busy);
                        end
                        1: check_eq("geom_line_len", last_line_len, e.llen);
                        2: check_eq("geom_short_line_cnt", last_line_cnt, e.lcnt);
                        default: begin
                            check_eq("timeout_cycle", cyc, e.at);
                            check_eq("timeout_busy", busy, 0);
                        end
                    endcase
                end
            end
        end
    end

    task automatic push_evt(input int kind, input int fcnt, input int lcnt, input int llen,
                            input longint at, input bit exp_busy);
        evt_t e;
        e.kind = kind; e.fcnt = fcnt; e.lcnt = lcnt; e.llen = llen; e.at = at;
        e.exp_busy = exp_busy;
        evt_q.push_back(e);
    endtask

    // exp_evt: 0 none, 1 frame_done after busy drop, 2 drain timeout
    task automatic drive_frame(input int lines, input int bad_line, input int bad_len,
                               input bit gated, input int start_line, input int stop_line,
                               input int short_lcnt, input int busy_hold, input int exp_evt);
        int len;
        bit line_gated;
        if (busy_hold > 0) scaler_busy = 1'b1;
        if (short_lcnt > 0) push_evt(2, 0, short_lcnt, 0, -1, 1'b0);
        per_img_vsync = 1'b1;
        repeat (3) tick();
        per_img_vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < lines; l++) begin
            len = (l == bad_line) ? bad_len : HREF_LEN;
            line_gated = gated && (bad_line < 0 || l <= bad_line);
            for (int p = 0; p < len; p++) begin
                per_img_href = 1'b1;
                per_img_gray = 8'($urandom);
                if (line_gated) pix_q.push_back(per_img_gray);
                start = (l == start_line && p == 0);
                stop  = (l == stop_line && p == 0);
                tick();
            end
            start = 1'b0;
            stop = 1'b0;
            per_img_href = 1'b0;
            per_img_gray = 8'd0;
            if (l == bad_line) push_evt(1, 0, 0, bad_len, -1, 1'b0);
            if (l == lines - 1 && exp_evt == 2) push_evt(3, 0, 0, 0, cyc + 2 + DRAIN_TO, 1'b0);
            repeat (8) tick();
        end
        if (busy_hold > 0) begin
            repeat (busy_hold) tick();
            scaler_busy = 1'b0;
            if (exp_evt == 1) begin
                exp_frames++;
                push_evt(0, exp_frames, HEIGHT, HREF_LEN, cyc + 3,
                         continuous && (stop_line < 0));
            end
        end
        repeat (8) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gate_href", gate_img_href, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_last_line_len", last_line_len, 0);
        check_eq("rst_last_line_cnt", last_line_cnt, 0);
        check_eq("rst_pulses", {frame_done, geom_err, timeout_err}, 0);
        rst = 1'b0;
        tick();

        // start and stop together in IDLE: stays idle, next frame not gated
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        check_eq("start_stop_busy", busy, 0);
        drive_frame(HEIGHT, -1, 0, 1'b0, -1, -1, 0, 0, 0);

        // nominal single-shot
        continuous = 1'b0;
        pulse_start();
        check_eq("armed_busy", busy, 1);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, 20, 1);
        check_eq("nominal_idle", busy, 0);

        // start mid-frame: that frame is not gated, the next completes
        drive_frame(HEIGHT, -1, 0, 1'b0, 3, -1, 0, 0, 0);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, 20, 1);

        // short line: gate closes after it, controller re-arms for the next frame
        pulse_start();
        drive_frame(HEIGHT, 2, HREF_LEN - 1, 1'b1, -1, -1, 0, 0, 0);
        check_eq("rearm_busy", busy, 1);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, 20, 1);

        // short frame: flagged at the next vsync rise, which is still gated through
        pulse_start();
        drive_frame(HEIGHT - 3, -1, 0, 1'b1, -1, -1, 0, 0, 0);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, HEIGHT - 3, 20, 1);

        // continuous with stop during frame 3; frame 4 must not be gated
        continuous = 1'b1;
        pulse_start();
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, 20, 1);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, 20, 1);
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, 4, 0, 20, 1);
        drive_frame(HEIGHT, -1, 0, 1'b0, -1, -1, 0, 0, 0);
        check_eq("stop_idle", busy, 0);
        check_eq("stop_frame_cnt", frame_cnt, exp_frames);
        continuous = 1'b0;

        // drain timeout with the scaler stuck busy
        pulse_start();
        drive_frame(HEIGHT, -1, 0, 1'b1, -1, -1, 0, DRAIN_TO + 30, 2);
        check_eq("timeout_frame_cnt", frame_cnt, exp_frames);

        // asynchronous reset in the middle of a gated line
        pulse_start();
        per_img_vsync = 1'b1;
        repeat (2) tick();
        per_img_vsync = 1'b0;
        repeat (2) tick();
        for (int p = 0; p < 3; p++) begin
            per_img_href = 1'b1;
            per_img_gray = 8'($urandom_range(1, 255));
            pix_q.push_back(per_img_gray);
            tick();
        end
        check_eq("pre_rst_gate_href", gate_img_href, 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_gate_href", gate_img_href, 0);
        check_eq("midrst_gate_gray", gate_img_gray, 0);
        check_eq("midrst_gate_vsync", gate_img_vsync, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_frame_cnt", frame_cnt, 0);
        check_eq("midrst_line_len", last_line_len, 0);
        pix_q.delete();
        per_img_href = 1'b0;
        per_img_gray = 8'd0;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        check_eq("pixels_outstanding", pix_q.size(), 0);
        check_eq("events_outstanding", evt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
